// File: rtl/apb_bridge_arbiter.sv
// apb_bridge_arbiter: round-robin arbiter for two requesters (m0 = CPU, m1 = DMA)
// that sequences one NONSEQ address phase and one data phase per transfer
// into the AHB slave port of the AHB-to-APB bridge.
//
// Ports
//   hclk, hresetn        clock (rising edge), async active-low reset
//   mN_req/write/addr/wdata  requester N transfer request, held until mN_done
//   mN_gnt               requester N owns the bridge (ADDR and DATA phases)
//   mN_done/mN_rdata     1-cycle completion pulse and read data to requester N
//   err                  valid with mN_done: hresp error or timeout
//   hselapb/htrans/haddr/hwrite/hwdata  AHB-side request to the bridge
//   hready/hresp/hrdata  AHB-side response from the bridge
//
// Optional feature: define APB_ARB_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYCLES hready-low cycles (done with err=1, rdata=0).
module apb_bridge_arbiter #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic          hclk,
   input  logic          hresetn,
   input  logic          m0_req,
   input  logic          m0_write,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_done,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_write,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_done,
   output logic [DW-1:0] m1_rdata,
   output logic          err,
   output logic          hselapb,
   output logic [1:0]    htrans,
   output logic [AW-1:0] haddr,
   output logic          hwrite,
   output logic [DW-1:0] hwdata,
   input  logic          hready,
   input  logic          hresp,
   input  logic [DW-1:0] hrdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic          rr_last;
   logic          any_req;
   logic          win;
   logic          take;
   logic          finish;
   logic          abort;
   logic          tmo_hit;
   logic [AW-1:0] addr_q;
   logic          write_q;
   logic [DW-1:0] wdata_q;

   // On a tie the requester that did not win last time gets the bus;
   // rr_last resets to 1 so m0 wins the first tie.
   assign any_req = m0_req | m1_req;
   assign win     = (m0_req & m1_req) ? ~rr_last : m1_req;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] tmo_cnt;

   // Hit on the TIMEOUT_CYCLES-th hready-low cycle of the transfer.
   assign tmo_hit = (state != IDLE) && !hready &&
                    (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         tmo_cnt <= '0;
      end else if (take) begin
         tmo_cnt <= '0;
      end else if ((state != IDLE) && !hready && !tmo_hit) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      finish    = 1'b0;
      abort     = 1'b0;
      unique case (state)
         IDLE: begin
            if (any_req) begin
               take      = 1'b1;
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            if (hready) begin
               state_nxt = DATA;
            end else if (tmo_hit) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         DATA: begin
            if (hready) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end else if (tmo_hit) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign hselapb = (state == ADDR);
   assign htrans  = (state == ADDR) ? 2'b10 : 2'b00;
   assign haddr   = addr_q;
   assign hwrite  = write_q;
   assign hwdata  = wdata_q;

   // The granted requester is identified by m1_gnt while a transfer is
   // in flight, so no separate owner register is kept.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         rr_last  <= 1'b1;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         m0_gnt   <= 1'b0;
         m1_gnt   <= 1'b0;
         m0_done  <= 1'b0;
         m1_done  <= 1'b0;
         m0_rdata <= '0;
         m1_rdata <= '0;
         err      <= 1'b0;
      end else begin
         m0_done <= 1'b0;
         m1_done <= 1'b0;
         err     <= 1'b0;
         if (take) begin
            rr_last <= win;
            m0_gnt  <= ~win;
            m1_gnt  <= win;
            addr_q  <= win ? m1_addr : m0_addr;
            write_q <= win ? m1_write : m0_write;
            wdata_q <= win ? m1_wdata : m0_wdata;
         end
         if (finish || abort) begin
            m0_gnt <= 1'b0;
            m1_gnt <= 1'b0;
            err    <= abort | hresp;
            if (m1_gnt) begin
               m1_done <= 1'b1;
               if (abort) begin
                  m1_rdata <= '0;
               end else if (!write_q) begin
                  m1_rdata <= hrdata;
               end
            end else begin
               m0_done <= 1'b1;
               if (abort) begin
                  m0_rdata <= '0;
               end else if (!write_q) begin
                  m0_rdata <= hrdata;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// tb_apb_bridge_arbiter: directed and randomized transfers against a
// transaction-level model of arbitration, phase timing and read data.
module tb_apb_bridge_arbiter;

   logic        hclk;
   logic        hresetn;
   logic        m0_req;
   logic        m0_write;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_gnt;
   logic        m0_done;
   logic [31:0] m0_rdata;
   logic        m1_req;
   logic        m1_write;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_gnt;
   logic        m1_done;
   logic [31:0] m1_rdata;
   logic        err;
   logic        hselapb;
   logic [1:0]  htrans;
   logic [31:0] haddr;
   logic        hwrite;
   logic [31:0] hwdata;
   logic        hready;
   logic        hresp;
   logic [31:0] hrdata;

   int passed;
   int total;

   // Model state: who won the last tie-break and last read data per port.
   bit          last;
   logic [31:0] exp_rd [2];

   apb_bridge_arbiter #(
      .AW(32),
      .DW(32),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .hclk(hclk),
      .hresetn(hresetn),
      .m0_req(m0_req),
      .m0_write(m0_write),
      .m0_addr(m0_addr),
      .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt),
      .m0_done(m0_done),
      .m0_rdata(m0_rdata),
      .m1_req(m1_req),
      .m1_write(m1_write),
      .m1_addr(m1_addr),
      .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt),
      .m1_done(m1_done),
      .m1_rdata(m1_rdata),
      .err(err),
      .hselapb(hselapb),
      .htrans(htrans),
      .haddr(haddr),
      .hwrite(hwrite),
      .hwdata(hwdata),
      .hready(hready),
      .hresp(hresp),
      .hrdata(hrdata)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   // Runs one transfer using the requests currently driven; wa/wd are
   // hready-low cycles in the address and data phases.
   task automatic xfer(input int wa, input int wd, input logic resp,
                       input logic [31:0] rd);
      bit          w;
      logic [31:0] ea;
      logic [31:0] ed;
      logic        ewr;
      w   = (m0_req && m1_req) ? !last : m1_req;
      last = w;
      ea  = w ? m1_addr : m0_addr;
      ed  = w ? m1_wdata : m0_wdata;
      ewr = w ? m1_write : m0_write;
      hready = 1'b0;
      tick();
      chk("gnt0_addr", m0_gnt, !w);
      chk("gnt1_addr", m1_gnt, w);
      chk("htrans_addr", htrans, 2'b10);
      chk("hsel_addr", hselapb, 1'b1);
      chk("haddr", haddr, ea);
      chk("hwrite", hwrite, ewr);
      chk("done_clear", {m0_done, m1_done}, 2'b00);
      for (int i = 0; i < wa; i++) begin
         hresp = 1'($urandom);
         tick();
         chk("hold_addr", htrans, 2'b10);
      end
      hready = 1'b1;
      hresp  = 1'($urandom);
      tick();
      chk("htrans_data", htrans, 2'b00);
      chk("hsel_data", hselapb, 1'b0);
      chk("haddr_held", haddr, ea);
      chk("gnt_data", {m1_gnt, m0_gnt}, w ? 2'b10 : 2'b01);
      if (ewr) chk("hwdata", hwdata, ed);
      for (int i = 0; i < wd; i++) begin
         hready = 1'b0;
         hresp  = 1'($urandom);
         tick();
         chk("wait_nodone", {m0_done, m1_done}, 2'b00);
         chk("wait_gnt", {m1_gnt, m0_gnt}, w ? 2'b10 : 2'b01);
         if (ewr) chk("hwdata_stable", hwdata, ed);
      end
      hready = 1'b1;
      hresp  = resp;
      hrdata = rd;
      tick();
      hready = 1'b0;
      hresp  = 1'b0;
      hrdata = $urandom;
      if (!ewr) exp_rd[w] = rd;
      chk("done_win", {m1_done, m0_done}, w ? 2'b10 : 2'b01);
      chk("err", err, resp);
      chk("rdata0", m0_rdata, exp_rd[0]);
      chk("rdata1", m1_rdata, exp_rd[1]);
      chk("gnt_drop", {m1_gnt, m0_gnt}, 2'b00);
      m0_req = 1'b0;
      m1_req = 1'b0;
   endtask

   task automatic set_m(input bit p, input bit r, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
      if (p) begin
         m1_req = r; m1_write = wr; m1_addr = a; m1_wdata = d;
      end else begin
         m0_req = r; m0_write = wr; m0_addr = a; m0_wdata = d;
      end
   endtask

   initial begin
      logic [1:0] r;
      passed   = 0;
      total    = 0;
      last     = 1'b1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      hresetn  = 1'b0;
      m0_req = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
      hready = 0; hresp = 0; hrdata = '0;
      tick();
      tick();
      chk("rst_gnt", {m0_gnt, m1_gnt}, 2'b00);
      chk("rst_done", {m0_done, m1_done, err}, 3'b000);
      chk("rst_htrans", htrans, 2'b00);
      chk("rst_hsel", hselapb, 1'b0);
      chk("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
      hresetn = 1'b1;
      tick();
      chk("idle_noreq", {m0_gnt, m1_gnt, hselapb}, 3'b000);

      // Plain m0 read.
      set_m(0, 1, 0, 32'h0000_0040, 32'h1111_1111);
      xfer(0, 0, 1'b0, 32'hCAFE_F00D);

      // Tie held for four transfers: grants alternate.
      for (int i = 0; i < 4; i++) begin
         set_m(0, 1, 0, 32'h100 + i, 32'h0);
         set_m(1, 1, 0, 32'h200 + i, 32'h0);
         xfer(0, 0, 1'b0, $urandom);
      end

      // m1 write with three data-phase wait states.
      set_m(1, 1, 1, 32'h0000_0010, 32'hA5A5_A5A5);
      xfer(0, 3, 1'b0, 32'hDEAD_0000);

      // Error response, then a clean transfer.
      set_m(0, 1, 0, 32'h44, 32'h0);
      xfer(1, 0, 1'b1, 32'h1234_5678);
      set_m(0, 1, 1, 32'h48, 32'h8765_4321);
      xfer(0, 0, 1'b0, 32'h0);

      // Reset while m0 is in its data phase; last winner was m0.
      set_m(0, 1, 0, 32'h80, 32'h0);
      hready = 1'b1;
      tick();
      tick();
      chk("pre_rst_data", {m0_gnt, htrans}, 3'b100);
      hready = 1'b0;
      hresetn = 1'b0;
      #1;
      chk("arst_gnt", {m0_gnt, m1_gnt}, 2'b00);
      chk("arst_out", {hselapb, htrans, err, m0_done}, 5'b0);
      chk("arst_haddr", haddr, 32'h0);
      tick();
      chk("arst_nodone", {m0_done, m1_done}, 2'b00);
      hresetn = 1'b1;
      last = 1'b1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      m0_req = 1'b0;
      tick();
      set_m(0, 1, 0, 32'h90, 32'h0);
      set_m(1, 1, 0, 32'h94, 32'h0);
      xfer(0, 0, 1'b0, 32'h0BAD_F00D);

      // hready stuck low in the data phase of an m1 read.
`ifdef APB_ARB_TIMEOUT_EN
      set_m(1, 1, 0, 32'hC0, 32'h0);
      last = 1'b1;
      hready = 1'b1;
      tick();
      tick();
      hready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("tmo_wait", {m1_done, m1_gnt}, 2'b01);
      end
      tick();
      chk("tmo_done", {m1_done, err}, 2'b11);
      chk("tmo_rdata", m1_rdata, 32'h0);
      chk("tmo_idle", {m1_gnt, htrans}, 3'b000);
      exp_rd[1] = '0;
      m1_req = 1'b0;
`else
      set_m(1, 1, 0, 32'hC0, 32'h0);
      xfer(0, 20, 1'b0, 32'h5EED_0001);
`endif

      // Randomized transfers.
      for (int n = 0; n < 40; n++) begin
         r = 2'($urandom_range(1, 3));
         set_m(0, r[0], 1'($urandom), $urandom, $urandom);
         set_m(1, r[1], 1'($urandom), $urandom, $urandom);
         xfer($urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0), $urandom);
         if ($urandom_range(0, 1) == 1) begin
            tick();
            chk("rand_idle", {m0_gnt, m1_gnt, hselapb}, 3'b000);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
